// File: rtl/flash_audio_player.sv
// rtl/flash_audio_player.sv - streams 8-bit audio samples from flash words, two samples per word
module flash_audio_player #(
  parameter int ADDR_W     = 23,
  parameter int SAMPLE_MSB = 15
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_play,
  input  logic [ADDR_W-1:0] i_start_addr,
  input  logic [ADDR_W-1:0] i_end_addr,
  input  logic              i_abort,
  input  logic              i_sample_tick,
  output logic              o_flash_read,
  output logic [ADDR_W-1:0] o_flash_address,
  input  logic              i_flash_waitrequest,
  input  logic [31:0]       i_flash_readdata,
  input  logic              i_flash_readdatavalid,
  output logic [7:0]        o_audio_signal,
  output logic              o_sample_strobe,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_underrun
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT_DATA,
    S_WAIT_LO,
    S_WAIT_HI,
    S_NEXT
  } state_t;

  state_t            r_state;
  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W-1:0] r_last;
  logic [7:0]        r_lo;
  logic [7:0]        r_hi;
  logic              r_abort_pend;
  logic              r_flash_read;
  logic [7:0]        r_audio;
  logic              r_strobe;
  logic              r_busy;
  logic              r_done;
  logic              r_underrun;

  // Only the two sample bytes of each word are kept; the rest of the bus is don't-care.
  logic w_unused_rdata;
  assign w_unused_rdata = ^i_flash_readdata;

  // Playback sequencer: one outstanding flash read, then two tick-paced samples per word.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state      <= S_IDLE;
      r_addr       <= '0;
      r_last       <= '0;
      r_lo         <= '0;
      r_hi         <= '0;
      r_abort_pend <= 1'b0;
      r_flash_read <= 1'b0;
      r_audio      <= '0;
      r_strobe     <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_underrun   <= 1'b0;
    end else begin
      r_strobe   <= 1'b0;
      r_done     <= 1'b0;
      r_underrun <= 1'b0;
      case (r_state)
        S_IDLE: begin
          // abort is meaningless here; a tick in the play cycle has nothing to emit yet
          if (i_play) begin
            r_addr       <= i_start_addr;
            r_last       <= i_end_addr;
            r_abort_pend <= 1'b0;
            if (i_start_addr > i_end_addr) begin
              r_done <= 1'b1;
            end else begin
              r_busy       <= 1'b1;
              r_flash_read <= 1'b1;
              r_state      <= S_REQ;
            end
          end
        end
        S_REQ: begin
          // the read cannot be withdrawn, so an abort waits for the data to return
          if (i_abort) r_abort_pend <= 1'b1;
          if (i_sample_tick) r_underrun <= 1'b1;
          if (!i_flash_waitrequest) begin
            r_flash_read <= 1'b0;
            r_state      <= S_WAIT_DATA;
          end
        end
        S_WAIT_DATA: begin
          if (i_sample_tick) r_underrun <= 1'b1;
          if (i_flash_readdatavalid) begin
            r_lo <= i_flash_readdata[SAMPLE_MSB -: 8];
            r_hi <= i_flash_readdata[16+SAMPLE_MSB -: 8];
            if (r_abort_pend || i_abort) begin
              r_done       <= 1'b1;
              r_busy       <= 1'b0;
              r_audio      <= '0;
              r_abort_pend <= 1'b0;
              r_state      <= S_IDLE;
            end else begin
              r_state <= S_WAIT_LO;
            end
          end else if (i_abort) begin
            r_abort_pend <= 1'b1;
          end
        end
        S_WAIT_LO: begin
          if (i_abort) begin
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_audio <= '0;
            r_state <= S_IDLE;
          end else if (i_sample_tick) begin
            r_audio  <= r_lo;
            r_strobe <= 1'b1;
            r_state  <= S_WAIT_HI;
          end
        end
        S_WAIT_HI: begin
          if (i_abort) begin
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_audio <= '0;
            r_state <= S_IDLE;
          end else if (i_sample_tick) begin
            r_audio  <= r_hi;
            r_strobe <= 1'b1;
            r_state  <= S_NEXT;
          end
        end
        S_NEXT: begin
          // compare before incrementing so the top address never wraps to zero
          if (i_sample_tick) r_underrun <= 1'b1;
          if (i_abort || (r_addr == r_last)) begin
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_audio <= '0;
            r_state <= S_IDLE;
          end else begin
            r_addr       <= r_addr + 1'b1;
            r_flash_read <= 1'b1;
            r_state      <= S_REQ;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign o_flash_read    = r_flash_read;
  assign o_flash_address = r_addr;
  assign o_audio_signal  = r_audio;
  assign o_sample_strobe = r_strobe;
  assign o_busy          = r_busy;
  assign o_done          = r_done;
  assign o_underrun      = r_underrun;

endmodule
